// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: screen geometry, bus widths and the
// timing/pixel bundle that travels alongside every pixel.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
    localparam int CNT_W      = 11;
    localparam int RGB_W      = 12;

    // One pixel's worth of timing plus colour, kept together so that every
    // pipeline stage delays all of it by the same amount.
    typedef struct packed {
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [RGB_W-1:0] rgb;
    } vga_if_t;

endpackage

// File: rtl/vga_delay.sv
// N-stage register delay for a complete VGA timing/pixel bundle.
module vga_delay
    import vga_pkg::*;
#(
    parameter int N = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  vga_if_t src,
    output vga_if_t dly
);

    vga_if_t stage_q [N];

    // Shift the bundle one stage per clock; reset empties the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every stage is cleared on reset because its contents
            // drive outputs directly; this is a pipeline, not a storage
            // memory, so the reset costs nothing meaningful.
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= src;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dly = stage_q[N-1];

endmodule

// File: rtl/sprite_draw_ctrl.sv
// Sprite overlay stage: windows the beam against the latched sprite
// position, addresses the sprite ROM, realigns VGA timing with the ROM data
// and composes the sprite over the background with colour-key transparency.
module sprite_draw_ctrl
    import vga_pkg::*;
#(
    parameter int          SPRITE_W = 64,
    parameter int          SPRITE_H = 48,
    parameter int          ADDR_W   = 12,
    parameter logic [11:0] KEY_RGB  = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       vcount_in,
    input  logic [10:0]       hcount_in,
    input  logic              vsync_in,
    input  logic              hsync_in,
    input  logic              vblnk_in,
    input  logic              hblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              spr_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_rgb,
    output logic [10:0]       vcount_out,
    output logic [10:0]       hcount_out,
    output logic              vsync_out,
    output logic              hsync_out,
    output logic              vblnk_out,
    output logic              hblnk_out,
    output logic [11:0]       rgb_out,
    output logic              frame_done
);

    localparam logic [11:0]       SPR_W12   = 12'(SPRITE_W);
    localparam logic [11:0]       SPR_H12   = 12'(SPRITE_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_W * SPRITE_H - 1);

    typedef enum logic {
        WAIT_FS = 1'b0,
        ACCEPT  = 1'b1
    } hs_state_t;

    hs_state_t         state_q, state_d;
    logic              accept;
    logic              fs;
    logic [10:0]       xpos_l, ypos_l;
    logic              en_l;
    logic [10:0]       x_eff, y_eff;
    logic              en_eff;
    logic [11:0]       dx, dy;
    logic              hit_s0, last_s0;
    logic [ADDR_W-1:0] addr_s0;
    logic              hit_q, last_q;
    vga_if_t           s0_bus, s1_bus, s1_mix, s2_bus;

    // ------------------------------------------------------------------
    // Position handshake: offers are taken only on the frame-start pixel.
    // ------------------------------------------------------------------
    assign fs = (vcount_in == '0) && (hcount_in == '0);

    // Next-state and accept decode for the frame-start handshake.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            WAIT_FS: begin
                if (fs && pos_valid) begin
                    accept  = rst_n;
                    state_d = ACCEPT;
                end
            end
            ACCEPT:  state_d = WAIT_FS;
            default: state_d = WAIT_FS;
        endcase
    end

    assign pos_ready = accept;

    // Handshake state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state_q <= WAIT_FS;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame-stable copy of position and enable, updated only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xpos_l <= '0;
            ypos_l <= '0;
            en_l   <= 1'b0;
        end else if (accept) begin
            xpos_l <= xpos;
            ypos_l <= ypos;
            en_l   <= spr_en;
        end
    end

    // The frame-start pixel itself already belongs to the new frame, so it
    // sees the values being accepted rather than the stale latch.
    assign x_eff  = accept ? xpos   : xpos_l;
    assign y_eff  = accept ? ypos   : ypos_l;
    assign en_eff = accept ? spr_en : en_l;

    // ------------------------------------------------------------------
    // Stage 1: window test and ROM addressing.
    // ------------------------------------------------------------------
    // 12-bit differences: a beam left of / above the sprite wraps to a large
    // value and fails the range test on its own.
    assign dx = {1'b0, hcount_in} - {1'b0, x_eff};
    assign dy = {1'b0, vcount_in} - {1'b0, y_eff};

    // Hit decode and in-sprite address for the current beam position.
    always_comb begin
        hit_s0  = en_eff && (hcount_in >= x_eff) && (dx < SPR_W12)
                         && (vcount_in >= y_eff) && (dy < SPR_H12)
                         && !hblnk_in && !vblnk_in;
        addr_s0 = '0;
        if (hit_s0) begin
            addr_s0 = ADDR_W'(32'(dy) * 32'(SPRITE_W) + 32'(dx));
        end
        last_s0 = hit_s0 && (addr_s0 == LAST_ADDR);
    end

    assign s0_bus.vcount = vcount_in;
    assign s0_bus.vsync  = vsync_in;
    assign s0_bus.vblnk  = vblnk_in;
    assign s0_bus.hcount = hcount_in;
    assign s0_bus.hsync  = hsync_in;
    assign s0_bus.hblnk  = hblnk_in;
    assign s0_bus.rgb    = rgb_in;

    vga_delay #(.N(1)) u_stage1_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .src   (s0_bus),
        .dly   (s1_bus)
    );

    // Stage-1 registers travelling with the timing bundle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
            hit_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            rom_addr <= addr_s0;
            hit_q    <= hit_s0;
            last_q   <= last_s0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: compose sprite over background as ROM data returns.
    // ------------------------------------------------------------------
    // Replace the background colour with opaque sprite pixels.
    always_comb begin
        s1_mix = s1_bus;
        if (hit_q && (rom_rgb != KEY_RGB)) begin
            s1_mix.rgb = rom_rgb;
        end
    end

    vga_delay #(.N(1)) u_stage2_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .src   (s1_mix),
        .dly   (s2_bus)
    );

    // End-of-sprite pulse aligned with the composed pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_q;
        end
    end

    assign vcount_out = s2_bus.vcount;
    assign hcount_out = s2_bus.hcount;
    assign vsync_out  = s2_bus.vsync;
    assign hsync_out  = s2_bus.hsync;
    assign vblnk_out  = s2_bus.vblnk;
    assign hblnk_out  = s2_bus.hblnk;
    assign rgb_out    = s2_bus.rgb;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Self-checking bench for sprite_draw_ctrl: a per-pixel reference model,
// a table of hand-derived single-pixel vectors and frame-level sequences.
module tb_sprite_draw_ctrl;

    localparam int          SW  = 64;
    localparam int          SH  = 48;
    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
    logic [11:0] rgb_in;
    logic        pos_valid, pos_ready;
    logic [10:0] xpos, ypos;
    logic        spr_en;
    logic [11:0] rom_addr, rom_rgb;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_out;
    logic        frame_done;

    always #5 clk = ~clk;

    sprite_draw_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vcount_in  (vcount_in),
        .hcount_in  (hcount_in),
        .vsync_in   (vsync_in),
        .hsync_in   (hsync_in),
        .vblnk_in   (vblnk_in),
        .hblnk_in   (hblnk_in),
        .rgb_in     (rgb_in),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .xpos       (xpos),
        .ypos       (ypos),
        .spr_en     (spr_en),
        .rom_addr   (rom_addr),
        .rom_rgb    (rom_rgb),
        .vcount_out (vcount_out),
        .hcount_out (hcount_out),
        .vsync_out  (vsync_out),
        .hsync_out  (hsync_out),
        .vblnk_out  (vblnk_out),
        .hblnk_out  (hblnk_out),
        .rgb_out    (rgb_out),
        .frame_done (frame_done)
    );

    // Sprite ROM contents; the ROM's address register is the DUT's rom_addr.
    logic [11:0] rom_mem [0:4095];
    assign rom_rgb = rom_mem[rom_addr];

    int tests  = 0;
    int failed = 0;

    // Reference model state: what the sprite position is for this frame.
    int m_x, m_y;
    bit m_en;

    typedef struct {
        logic [37:0] tim;
        logic        done;
    } exp_t;
    exp_t prev_exp;

    int done_cnt;
    int ready_cnt;
    int nz_addr_cnt;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] bg;
        logic [11:0] rom;
        logic [11:0] exp_addr;
        logic [11:0] exp_rgb;
        logic        exp_done;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // One pixel clock: predict from the sprite rules, clock, compare.
    task automatic step();
        bit          acc;
        bit          hit;
        int          dx, dy, addr;
        logic [11:0] pix, rgb, e_addr;
        exp_t        e;
        acc = rst_n && pos_valid && (vcount_in == 11'd0) && (hcount_in == 11'd0);
        #1;
        check("pos_ready", 64'(pos_ready), 64'(acc));
        if (pos_ready) ready_cnt++;
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_en = 1'b0;
        end else if (acc) begin
            m_x = int'(xpos); m_y = int'(ypos); m_en = spr_en;
        end
        dx   = int'(hcount_in) - m_x;
        dy   = int'(vcount_in) - m_y;
        hit  = m_en && dx >= 0 && dx < SW && dy >= 0 && dy < SH && !hblnk_in && !vblnk_in;
        addr = hit ? dy * SW + dx : 0;
        pix  = rom_mem[addr];
        rgb  = (hit && pix != KEY) ? pix : rgb_in;
        e.tim  = {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in, rgb};
        e.done = hit && (addr == SW * SH - 1);
        e_addr = 12'(addr);
        if (!rst_n) begin
            e.tim = '0; e.done = 1'b0; e_addr = '0;
            prev_exp.tim = '0; prev_exp.done = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rom_addr", 64'(rom_addr), 64'(e_addr));
        check("timing_rgb",
              64'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out}),
              64'(prev_exp.tim));
        check("frame_done", 64'(frame_done), 64'(prev_exp.done));
        if (frame_done) done_cnt++;
        if (rom_addr != '0) nz_addr_cnt++;
        prev_exp = e;
    endtask

    task automatic pix(input int v, input int h, input logic [11:0] rgb);
        vcount_in = 11'(v);
        hcount_in = 11'(h);
        hblnk_in  = (h >= 800);
        vblnk_in  = (v >= 600);
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
        rgb_in    = rgb;
        step();
    endtask

    task automatic sweep(input int v0, input int v1, input int h0, input int h1);
        for (int v = v0; v <= v1; v++) begin
            for (int h = h0; h <= h1; h++) begin
                if (!(v == 0 && h == 0)) pix(v, h, 12'($urandom));
            end
        end
        pix(650, 900, 12'h000);
        pix(650, 901, 12'h000);
    endtask

    // Offer a position at frame start, then scramble the offer lines to show
    // the accepted values hold for the frame.
    task automatic frame(input bit valid, input int x, input int y, input bit en,
                         input int v0, input int v1, input int h0, input int h1);
        pos_valid = valid;
        xpos      = 11'(x);
        ypos      = 11'(y);
        spr_en    = en;
        pix(0, 0, 12'($urandom));
        pos_valid = 1'b0;
        xpos      = 11'($urandom);
        ypos      = 11'($urandom);
        spr_en    = 1'($urandom);
        sweep(v0, v1, h0, h1);
    endtask

    task automatic fill_rom();
        for (int a = 0; a < 4096; a++) begin
            rom_mem[a] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
        end
    endtask

    initial begin
        tbl[0] = '{h:100, v:50, bg:12'h123, rom:12'hF0F, exp_addr:12'd0,    exp_rgb:12'h123, exp_done:1'b0};
        tbl[1] = '{h:100, v:50, bg:12'h123, rom:12'hFC0, exp_addr:12'd0,    exp_rgb:12'hFC0, exp_done:1'b0};
        tbl[2] = '{h:163, v:97, bg:12'h456, rom:12'h0AB, exp_addr:12'd3071, exp_rgb:12'h0AB, exp_done:1'b1};
        tbl[3] = '{h:99,  v:50, bg:12'h789, rom:12'hABC, exp_addr:12'd0,    exp_rgb:12'h789, exp_done:1'b0};
        tbl[4] = '{h:164, v:50, bg:12'h321, rom:12'hABC, exp_addr:12'd0,    exp_rgb:12'h321, exp_done:1'b0};
        tbl[5] = '{h:101, v:51, bg:12'h000, rom:12'h555, exp_addr:12'd65,   exp_rgb:12'h555, exp_done:1'b0};
        tbl[6] = '{h:163, v:50, bg:12'h0EE, rom:12'h777, exp_addr:12'd63,   exp_rgb:12'h777, exp_done:1'b0};
        tbl[7] = '{h:100, v:97, bg:12'h111, rom:12'h888, exp_addr:12'd3008, exp_rgb:12'h888, exp_done:1'b0};
        tbl[8] = '{h:100, v:49, bg:12'h222, rom:12'hABC, exp_addr:12'd0,    exp_rgb:12'h222, exp_done:1'b0};
        tbl[9] = '{h:100, v:98, bg:12'h333, rom:12'hABC, exp_addr:12'd0,    exp_rgb:12'h333, exp_done:1'b0};

        rst_n = 1'b0;
        vcount_in = '0; hcount_in = '0; vsync_in = 1'b0; hsync_in = 1'b0;
        vblnk_in = 1'b0; hblnk_in = 1'b0; rgb_in = '0;
        pos_valid = 1'b0; xpos = '0; ypos = '0; spr_en = 1'b0;
        m_x = 0; m_y = 0; m_en = 1'b0;
        prev_exp.tim = '0; prev_exp.done = 1'b0;
        done_cnt = 0; ready_cnt = 0; nz_addr_cnt = 0;
        fill_rom();

        // Power-on reset.
        pix(650, 900, 12'hFFF);
        pix(650, 901, 12'hFFF);
        check("reset_outputs",
              64'({rom_addr, vcount_out, hcount_out, vsync_out, hsync_out,
                   vblnk_out, hblnk_out, rgb_out, frame_done}), 64'd0);
        rst_n = 1'b1;

        // Handshake: offer raised mid-frame waits for frame start.
        pos_valid = 1'b1; xpos = 11'd100; ypos = 11'd50; spr_en = 1'b1;
        for (int h = 0; h < 10; h++) pix(300, h, 12'($urandom));
        check("ready_before_fs", 64'(ready_cnt), 64'd0);
        pix(0, 0, 12'h0F0);
        check("ready_at_fs", 64'(ready_cnt), 64'd1);
        pos_valid = 1'b0;
        done_cnt = 0;
        sweep(48, 99, 96, 168);
        check("ready_single_pulse", 64'(ready_cnt), 64'd1);
        check("done_full_sprite", 64'(done_cnt), 64'd1);

        // Single-pixel vectors against the sprite at (100,50).
        for (int i = 0; i < 10; i++) begin
            rom_mem[tbl[i].exp_addr] = tbl[i].rom;
            pix(tbl[i].v, tbl[i].h, tbl[i].bg);
            check($sformatf("vec%0d_addr", i), 64'(rom_addr), 64'(tbl[i].exp_addr));
            pix(650, 900, 12'h000);
            check($sformatf("vec%0d_rgb", i), 64'(rgb_out), 64'(tbl[i].exp_rgb));
            check($sformatf("vec%0d_done", i), 64'(frame_done), 64'(tbl[i].exp_done));
        end

        // Reset in the middle of a line, then in the middle of a sprite frame.
        fill_rom();
        for (int h = 90; h <= 110; h++) pix(50, h, 12'($urandom));
        rst_n = 1'b0;
        for (int h = 111; h <= 113; h++) pix(50, h, 12'($urandom));
        check("midline_reset_outputs",
              64'({rom_addr, vcount_out, hcount_out, vsync_out, hsync_out,
                   vblnk_out, hblnk_out, rgb_out, frame_done, pos_ready}), 64'd0);
        rst_n = 1'b1;
        for (int h = 114; h <= 130; h++) pix(50, h, 12'($urandom));
        done_cnt = 0;
        pos_valid = 1'b1; xpos = 11'd100; ypos = 11'd50; spr_en = 1'b1;
        pix(0, 0, 12'h000);
        pos_valid = 1'b0;
        for (int v = 48; v <= 70; v++) begin
            for (int h = 96; h <= 168; h++) pix(v, h, 12'($urandom));
        end
        rst_n = 1'b0;
        pix(71, 96, 12'h000);
        rst_n = 1'b1;
        sweep(71, 99, 96, 168);
        check("done_after_reset", 64'(done_cnt), 64'd0);

        // Right-edge clipping: only hcount 780..799 can hit.
        done_cnt = 0;
        frame(1'b1, 780, 50, 1'b1, 48, 99, 776, 830);
        check("done_clip_right", 64'(done_cnt), 64'd0);

        // Bottom-edge clipping.
        done_cnt = 0;
        frame(1'b1, 300, 580, 1'b1, 578, 627, 296, 370);
        check("done_clip_bottom", 64'(done_cnt), 64'd0);

        // Sprite at the origin: the frame-start pixel is itself a hit.
        done_cnt = 0;
        rom_mem[0] = 12'h0A5;
        pos_valid = 1'b1; xpos = 11'd0; ypos = 11'd0; spr_en = 1'b1;
        pix(0, 0, 12'h123);
        pos_valid = 1'b0;
        pix(0, 1, 12'h123);
        check("origin_rgb", 64'(rgb_out), 64'h0A5);
        for (int h = 2; h <= 66; h++) pix(0, h, 12'($urandom));
        sweep(1, 49, 0, 66);
        check("done_origin", 64'(done_cnt), 64'd1);

        // Disabled sprite: pure pass-through for a frame.
        done_cnt = 0; nz_addr_cnt = 0;
        frame(1'b1, 100, 50, 1'b0, 48, 99, 96, 168);
        check("disabled_addr_nonzero", 64'(nz_addr_cnt), 64'd0);
        check("disabled_done", 64'(done_cnt), 64'd0);

        // Random on-screen positions and ROM contents.
        for (int n = 0; n < 4; n++) begin
            int x, y;
            x = $urandom_range(0, 800 - SW);
            y = $urandom_range(0, 600 - SH);
            fill_rom();
            done_cnt = 0;
            frame(1'b1, x, y, 1'b1, (y >= 2) ? y - 2 : 0, y + SH + 1,
                  (x >= 3) ? x - 3 : 0, x + SW + 2);
            check($sformatf("rand%0d_done", n), 64'(done_cnt), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
